// File: rtl/mult_div_unit_pkg.sv
// Shared types for the multiply/divide unit: operation encoding, the HI/LO
// result-mux select used by the ALU, and small op-decoding helpers.
package mult_div_unit_pkg;

  typedef enum logic [1:0] {
    MDU_MULT  = 2'd0,
    MDU_MULTU = 2'd1,
    MDU_DIV   = 2'd2,
    MDU_DIVU  = 2'd3
  } mdu_op_t;

  // Result-mux select for MFHI/MFLO in the ALU output path.
  typedef enum logic [0:0] {
    MFHIac = 1'b0,
    MFLOac = 1'b1
  } alu_ctrl_t;

  function automatic logic is_div_op(input mdu_op_t o);
    return (o == MDU_DIV) || (o == MDU_DIVU);
  endfunction

  function automatic logic is_signed_op(input mdu_op_t o);
    return (o == MDU_MULT) || (o == MDU_DIV);
  endfunction

endpackage

// File: rtl/mdu_iter_core.sv
// Single iteration of the multiply/divide datapath. Operates on unsigned
// magnitudes only; sign handling lives in the owning FSM.
//   multiply: radix-2 shift-add, {upper,lower} is the 2*WIDTH accumulator,
//             lower starts as the multiplier, operand is the multiplicand.
//   divide:   restoring, upper is the partial remainder, lower shifts the
//             dividend out and the quotient bits in, operand is the divisor.
module mdu_iter_core #(
  parameter int WIDTH = 32
) (
  input  logic             is_div,
  input  logic [WIDTH-1:0] upper,
  input  logic [WIDTH-1:0] lower,
  input  logic [WIDTH-1:0] operand,
  output logic [WIDTH-1:0] upper_next,
  output logic [WIDTH-1:0] lower_next
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  // One shift-add or trial-subtract step.
  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    upper_next = upper;
    lower_next = lower;
    sum        = {1'b0, upper} + (lower[0] ? {1'b0, operand} : '0);
    shifted    = {upper, lower[WIDTH-1]};
    trial      = shifted - {1'b0, operand};
    if (is_div) begin
      // A clear borrow bit means the divisor fits: keep the difference.
      if (!trial[WIDTH]) begin
        upper_next = trial[WIDTH-1:0];
        lower_next = {lower[WIDTH-2:0], 1'b1};
      end else begin
        upper_next = shifted[WIDTH-1:0];
        lower_next = {lower[WIDTH-2:0], 1'b0};
      end
    end else begin
      // The carry out of the add becomes the top bit after the right shift.
      upper_next = sum[WIDTH:1];
      lower_next = {sum[0], lower[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit owning the HI/LO register pair. An accepted
// start runs WIDTH iterations in CALC, then one FIX cycle applies the signs
// and writes HI/LO while done pulses on the following cycle.
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  mdu_op_t          op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  input  logic             wr_hi,
  input  logic             wr_lo,
  input  logic [WIDTH-1:0] wr_data,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic             is_div, neg_q, neg_r, div_zero;
  logic [WIDTH-1:0] upper, lower, operand, a_raw;
  logic [WIDTH-1:0] upper_next, lower_next;

  logic             op_div, sign_a, sign_b;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [2*WIDTH-1:0] product;
  logic [WIDTH-1:0] fix_hi, fix_lo;

  mdu_iter_core #(.WIDTH(WIDTH)) u_core (
    .is_div    (is_div),
    .upper     (upper),
    .lower     (lower),
    .operand   (operand),
    .upper_next(upper_next),
    .lower_next(lower_next)
  );

  // Operand decode at start: magnitudes plus the sign of each operand.
  always_comb begin
    op_div = is_div_op(op);
    sign_a = is_signed_op(op) & a[WIDTH-1];
    sign_b = is_signed_op(op) & b[WIDTH-1];
    mag_a  = sign_a ? -a : a;
    mag_b  = sign_b ? -b : b;
  end

  // Final HI/LO values: sign-correct the magnitude result, or the
  // divide-by-zero pattern (all-ones quotient, dividend as sampled).
  always_comb begin
    product = {upper, lower};
    if (neg_q) product = -product;
    fix_hi = product[2*WIDTH-1:WIDTH];
    fix_lo = product[WIDTH-1:0];
    if (is_div) begin
      if (div_zero) begin
        fix_hi = a_raw;
        fix_lo = '1;
      end else begin
        fix_hi = neg_r ? -upper : upper;
        fix_lo = neg_q ? -lower : lower;
      end
    end
  end

  assign busy = (state != IDLE);

  // Control FSM, iteration registers and the architectural HI/LO pair.
  always_ff @(posedge clk) begin
    // NOTE: all state here uses non-blocking assignment so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      hi          <= '0;
      lo          <= '0;
      is_div      <= 1'b0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      div_zero    <= 1'b0;
      upper       <= '0;
      lower       <= '0;
      operand     <= '0;
      a_raw       <= '0;
    end else begin
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      case (state)
        IDLE: begin
          if (wr_hi) hi <= wr_data;
          if (wr_lo) lo <= wr_data;
          if (start && !cancel) begin
            state    <= CALC;
            cnt      <= '0;
            is_div   <= op_div;
            neg_q    <= sign_a ^ sign_b;
            neg_r    <= sign_a;
            div_zero <= op_div && (b == '0);
            a_raw    <= a;
            upper    <= '0;
            lower    <= op_div ? mag_a : mag_b;
            operand  <= op_div ? mag_b : mag_a;
          end
        end
        CALC: begin
          if (cancel) begin
            state <= IDLE;
          end else begin
            upper <= upper_next;
            lower <= lower_next;
            cnt   <= cnt + CW'(1);
            if (cnt == LAST) state <= FIX;
          end
        end
        FIX: begin
          state <= IDLE;
          if (!cancel) begin
            hi          <= fix_hi;
            lo          <= fix_lo;
            done        <= 1'b1;
            div_by_zero <= div_zero;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
